// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings up the board rPLL from its 27 MHz reference. Holds the PLL in reset
//   for a fixed time, waits for a synchronised and stable LOCK, and retries on
//   timeout up to a retry limit before parking in FAIL. While running, a
//   filtered loss of lock sends the sequence back to reset. Downstream logic is
//   held in reset until the PLL is stably locked. Everything runs on clkin_i.
//
// Ports
//   clkin_i      reference clock (27 MHz)
//   reset_i      asynchronous active-high reset
//   pll_lock_i   rPLL LOCK, asynchronous to clkin_i
//   restart_i    synchronous pulse: restart acquisition from any state
//   pll_reset_o  drives rPLL RESET
//   sys_reset_o  active-high reset for downstream logic
//   locked_o     high only in RUN
//   fail_o       high only in FAIL
//   retry_cnt_o  failed attempts in the current acquisition
//   loss_cnt_o   lock-loss events since reset, saturating at 255
//   state_o      0=RESET_HOLD 1=WAIT_LOCK 2=RUN 3=FAIL
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOSS_FILTER  = 4,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clkin_i,
  input  logic       reset_i,
  input  logic       pll_lock_i,
  input  logic       restart_i,
  output logic       pll_reset_o,
  output logic       sys_reset_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] loss_cnt_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_WAIT_LOCK  = 2'd1,
    ST_RUN        = 2'd2,
    ST_FAIL       = 2'd3
  } state_e;

  // Terminal compare values: each counter stops where its transition fires.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic             sync1_q, lock_q;
  // cnt: reset-hold length in RESET_HOLD, timeout in WAIT_LOCK.
  // qual: consecutive-lock count in WAIT_LOCK, consecutive-unlock count in RUN.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] qual_q, qual_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clkin_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      sync1_q <= pll_lock_i;
      lock_q  <= sync1_q;
    end
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qual_d  = qual_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (restart_i) begin
      // restart beats every other transition, but keeps the loss history
      state_d = ST_RESET_HOLD;
      cnt_d   = '0;
      qual_d  = '0;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_RESET_HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            qual_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // stable lock is tested first so it wins a tie with the timeout
          if (lock_q && (qual_q == STABLE_LAST)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            qual_d  = '0;
            retry_d = 4'd0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d   = '0;
            qual_d  = '0;
            retry_d = retry_q + 4'd1;
            if ((retry_q + 4'd1) == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_RESET_HOLD;
            end
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            qual_d = lock_q ? (qual_q + CNT_W'(1)) : '0;
          end
        end
        ST_RUN: begin
          if (lock_q) begin
            qual_d = '0;
          end else if (qual_q == LOSS_LAST) begin
            state_d = ST_RESET_HOLD;
            cnt_d   = '0;
            qual_d  = '0;
            if (loss_q != 8'hFF) begin
              loss_d = loss_q + 8'd1;
            end else begin
              loss_d = loss_q;
            end
          end else begin
            qual_d = qual_q + CNT_W'(1);
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET_HOLD;
          cnt_d   = '0;
          qual_d  = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as state_q.
    pll_reset_d = (state_d == ST_RESET_HOLD) || (state_d == ST_FAIL);
    sys_reset_d = (state_d != ST_RUN);
    locked_d    = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  // State, counters and output registers.
  always_ff @(posedge clkin_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_RESET_HOLD;
      cnt_q       <= '0;
      qual_q      <= '0;
      retry_q     <= 4'd0;
      loss_q      <= 8'd0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      qual_q      <= qual_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign sys_reset_o = sys_reset_q;
  assign locked_o    = locked_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;
  assign state_o     = state_q;

endmodule
